// File: rtl/aes_pkg.sv
// Shared AES types and constants: key-expander FSM states, round count and Rcon table.
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        DONE   = 2'd2
    } kexp_state_t;

    localparam int NUM_ROUNDS = 10;

    // Rcon[0] is never used by the schedule; entries 1..10 follow FIPS-197.
    localparam logic [7:0] RCON [0:10] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
        8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
    };

    function automatic logic [7:0] rcon_f(input logic [3:0] idx);
        if (idx <= 4'd10) begin
            rcon_f = RCON[idx];
        end else begin
            rcon_f = 8'h00;
        end
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box, shared between the key schedule and the cipher datapath.
module aes_sbox (
    input  logic [7:0] a,
    output logic [7:0] s
);

    // Entry 0 sits in the most significant byte, so SBOX[x] is the substitution of x.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    assign s = SBOX[a];

endmodule

// File: rtl/aes_key_expander.sv
// Iterative AES-128 key schedule: captures a key on start and derives one round key
// per cycle into an 11-entry register file readable by index or as a flat bus.
module aes_key_expander
    import aes_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [127:0]    key,
    output logic            busy,
    output logic            done,
    input  logic [3:0]      rk_sel,
    output logic [127:0]    rk_out,
    output logic [1407:0]   schedule
);

    kexp_state_t  state_r;
    kexp_state_t  state_s;
    logic [3:0]   cnt_r;
    logic [127:0] rk_r [0:NUM_ROUNDS];
    logic         busy_r;
    logic         done_r;

    logic [3:0]   prev_idx_s;
    logic [127:0] prev_rk_s;
    logic [31:0]  rot_s;
    logic [31:0]  sub_s;
    logic [31:0]  t_s;
    logic [127:0] next_rk_s;

    // Previous round key feeding the expansion step.
    always_comb begin
        if (cnt_r == 4'd0) begin
            prev_idx_s = 4'd0;
        end else begin
            prev_idx_s = cnt_r - 4'd1;
        end
        prev_rk_s = rk_r[prev_idx_s];
    end

    assign rot_s = {prev_rk_s[23:0], prev_rk_s[31:24]};

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_subword
            aes_sbox u_sbox (
                .a (rot_s[8*g +: 8]),
                .s (sub_s[8*g +: 8])
            );
        end
    endgenerate

    // One FIPS-197 round-key step: each word chains off the freshly computed one.
    always_comb begin
        t_s              = sub_s ^ {rcon_f(cnt_r), 24'h000000};
        next_rk_s[127:96] = prev_rk_s[127:96] ^ t_s;
        next_rk_s[95:64]  = prev_rk_s[95:64]  ^ next_rk_s[127:96];
        next_rk_s[63:32]  = prev_rk_s[63:32]  ^ next_rk_s[95:64];
        next_rk_s[31:0]   = prev_rk_s[31:0]   ^ next_rk_s[63:32];
    end

    // Next-state logic; DONE only releases once start has dropped.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    state_s = EXPAND;
                end else begin
                    state_s = IDLE;
                end
            end
            EXPAND: begin
                if (cnt_r == 4'(NUM_ROUNDS)) begin
                    state_s = DONE;
                end else begin
                    state_s = EXPAND;
                end
            end
            DONE: begin
                if (start) begin
                    state_s = DONE;
                end else begin
                    state_s = IDLE;
                end
            end
            default: state_s = IDLE;
        endcase
    end

    // State register and registered Moore status flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            busy_r  <= (state_s == EXPAND);
            done_r  <= (state_s == DONE);
        end
    end

    // Key capture, round-key writes and round counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= 4'd0;
            for (int i = 0; i <= NUM_ROUNDS; i++) begin
                rk_r[i] <= 128'h0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        rk_r[0] <= key;
                        cnt_r   <= 4'd1;
                    end
                end
                EXPAND: begin
                    rk_r[cnt_r] <= next_rk_s;
                    cnt_r       <= cnt_r + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Indexed read port; indices past round 10 read as zero.
    always_comb begin
        if (rk_sel <= 4'd10) begin
            rk_out = rk_r[rk_sel];
        end else begin
            rk_out = 128'h0;
        end
    end

    generate
        for (g = 0; g <= NUM_ROUNDS; g++) begin : g_sched
            assign schedule[128*g +: 128] = rk_r[g];
        end
    endgenerate

    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: tb/tb_aes_key_expander.sv
// Directed testbench for aes_key_expander using FIPS-197 key schedule vectors.
module tb_aes_key_expander;

    logic          clk;
    logic          reset;
    logic          start;
    logic [127:0]  key;
    logic          busy;
    logic          done;
    logic [3:0]    rk_sel;
    logic [127:0]  rk_out;
    logic [1407:0] schedule;

    int checks;
    int failures;

    localparam logic [127:0] KEY_A    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] KEY_A_R1 = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] KEY_A_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_B    = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] KEY_B_R1 = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] KEY_B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    aes_key_expander dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .busy     (busy),
        .done     (done),
        .rk_sel   (rk_sel),
        .rk_out   (rk_out),
        .schedule (schedule)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Raise start and count edges until done appears (bounded at 40 edges).
    task automatic run_expansion(input logic [127:0] k, output int edges);
        key   = k;
        start = 1'b1;
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            edges++;
            if (done) break;
        end
    endtask

    task automatic go_idle();
        start = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        start  = 1'b0;
        key    = 128'h0;
        rk_sel = 4'd0;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags busy=%b done=%b expected 0 0", busy, done);
        end
        checks++;
        if (schedule !== 1408'h0) begin
            failures++;
            $display("FAIL reset_schedule got nonzero expected 0");
        end
        checks++;
        if (rk_out !== 128'h0) begin
            failures++;
            $display("FAIL reset_rk_out got %h expected 0", rk_out);
        end
    endtask

    task automatic test_fips_key();
        int n;
        key   = KEY_A;
        start = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++;
            $display("FAIL busy_after_capture busy=%b done=%b expected 1 0", busy, done);
        end
        n = 1;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 11) begin
            failures++;
            $display("FAIL latency_a got %0d edges expected 11", n);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL busy_in_done got %b expected 0", busy);
        end
        checks++;
        if (schedule[128*1 +: 128] !== KEY_A_R1) begin
            failures++;
            $display("FAIL a_rk1 got %h expected %h", schedule[128*1 +: 128], KEY_A_R1);
        end
        checks++;
        if (schedule[128*10 +: 128] !== KEY_A_R10) begin
            failures++;
            $display("FAIL a_rk10 got %h expected %h", schedule[128*10 +: 128], KEY_A_R10);
        end
        go_idle();
    endtask

    task automatic test_read_port();
        int n;
        run_expansion(KEY_B, n);
        checks++;
        if (n !== 11) begin
            failures++;
            $display("FAIL latency_b got %0d edges expected 11", n);
        end
        rk_sel = 4'd10; #1;
        checks++;
        if (rk_out !== KEY_B_R10) begin
            failures++;
            $display("FAIL b_rk10 got %h expected %h", rk_out, KEY_B_R10);
        end
        rk_sel = 4'd1; #1;
        checks++;
        if (rk_out !== KEY_B_R1) begin
            failures++;
            $display("FAIL b_rk1 got %h expected %h", rk_out, KEY_B_R1);
        end
        rk_sel = 4'd0; #1;
        checks++;
        if (rk_out !== KEY_B) begin
            failures++;
            $display("FAIL b_rk0 got %h expected %h", rk_out, KEY_B);
        end
        rk_sel = 4'd12; #1;
        checks++;
        if (rk_out !== 128'h0) begin
            failures++;
            $display("FAIL rk_sel_12 got %h expected 0", rk_out);
        end
        rk_sel = 4'd0;
        go_idle();
    endtask

    task automatic test_drop_start();
        int n;
        key   = KEY_A;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        key   = 128'hdeadbeefcafef00d0123456789abcdef;
        n = 3;
        for (int i = 0; i < 40; i++) begin
            if (done) break;
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (n !== 11) begin
            failures++;
            $display("FAIL latency_drop got %0d edges expected 11", n);
        end
        checks++;
        if (schedule[128*10 +: 128] !== KEY_A_R10 || schedule[127:0] !== KEY_A) begin
            failures++;
            $display("FAIL drop_schedule rk10=%h expected %h", schedule[128*10 +: 128], KEY_A_R10);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL done_pulse done=%b busy=%b expected 0 0", done, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL stays_idle busy=%b expected 0", busy);
        end
    endtask

    task automatic test_reset_mid_expand();
        int n;
        key   = KEY_A;
        start = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || schedule !== 1408'h0 || rk_out !== 128'h0) begin
            failures++;
            $display("FAIL async_reset busy=%b done=%b rk_out=%h expected all 0", busy, done, rk_out);
        end
        start = 1'b0;
        @(posedge clk); #2;
        reset = 1'b0;
        @(posedge clk); #1;
        run_expansion(KEY_B, n);
        checks++;
        if (n !== 11) begin
            failures++;
            $display("FAIL latency_after_reset got %0d edges expected 11", n);
        end
        checks++;
        if (schedule[128*10 +: 128] !== KEY_B_R10) begin
            failures++;
            $display("FAIL rk10_after_reset got %h expected %h", schedule[128*10 +: 128], KEY_B_R10);
        end
    endtask

    task automatic test_hold_in_done();
        int n;
        int bad;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (done !== 1'b1 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL hold_done bad_cycles=%0d expected 0", bad);
        end
        checks++;
        if (schedule[128*10 +: 128] !== KEY_B_R10 || schedule[127:0] !== KEY_B) begin
            failures++;
            $display("FAIL hold_schedule rk10=%h expected %h", schedule[128*10 +: 128], KEY_B_R10);
        end
        go_idle();
        checks++;
        if (done !== 1'b0) begin
            failures++;
            $display("FAIL done_release got %b expected 0", done);
        end
        run_expansion(KEY_A, n);
        checks++;
        if (n !== 11) begin
            failures++;
            $display("FAIL latency_restart got %0d edges expected 11", n);
        end
        checks++;
        if (schedule[128*10 +: 128] !== KEY_A_R10) begin
            failures++;
            $display("FAIL restart_rk10 got %h expected %h", schedule[128*10 +: 128], KEY_A_R10);
        end
        go_idle();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_fips_key();
        test_read_port();
        test_drop_start();
        test_reset_mid_expand();
        test_hold_in_done();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
